// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the two-requester quad-SPI bus arbiter.
package qspi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT,
        RELEASE,
        GUARD
    } arb_state_t;

    // Nibble phases: P0/P2 drive data with SCK low, P1/P3 raise SCK and sample.
    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    localparam logic REQ_UART = 1'b0;
    localparam logic REQ_MGMT = 1'b1;
    localparam int   NUM_REQ  = 2;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        return (idx == REQ_MGMT) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/qspi_bus_arbiter_if.sv
// Requester-side byte streams plus QSPI pad signals of the bus arbiter.
interface qspi_bus_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic [15:0] tx_data;
    logic [1:0]  tx_valid;
    logic [1:0]  tx_last;
    logic [1:0]  tx_ready;
    logic [7:0]  rx_data;
    logic [1:0]  rx_valid;
    logic        busy;
    logic [3:0]  qspi_io_in;
    logic [3:0]  qspi_io_out;
    logic [3:0]  qspi_io_oe;
    logic        qspi_csb;
    logic        qspi_sck;

    modport slave (
        input  req, tx_data, tx_valid, tx_last, qspi_io_in,
        output grant, tx_ready, rx_data, rx_valid, busy,
               qspi_io_out, qspi_io_oe, qspi_csb, qspi_sck
    );

    modport master (
        output req, tx_data, tx_valid, tx_last, qspi_io_in,
        input  grant, tx_ready, rx_data, rx_valid, busy,
               qspi_io_out, qspi_io_oe, qspi_csb, qspi_sck
    );
endinterface

// File: rtl/qspi_nibble_phy.sv
// Byte-in/byte-out nibble shifter: high nibble first, one SCK period per nibble.
module qspi_nibble_phy
    import qspi_arb_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic [3:0] io_in,
    output logic       sck,
    output logic [3:0] io_out,
    output logic       done,
    output logic [7:0] rx_byte
);

    localparam int                DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active_reg, active_next;
    logic [1:0]       phase_reg, phase_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [3:0]       lo_nib_reg, lo_nib_next;
    logic [7:0]       rx_reg, rx_next;
    logic             sck_reg, sck_next;
    logic [3:0]       io_out_reg, io_out_next;
    logic             done_reg, done_next;

    assign sck     = sck_reg;
    assign io_out  = io_out_reg;
    assign done    = done_reg;
    assign rx_byte = rx_reg;

    always_comb begin
        active_next = active_reg;
        phase_next  = phase_reg;
        div_next    = div_reg;
        lo_nib_next = lo_nib_reg;
        rx_next     = rx_reg;
        sck_next    = sck_reg;
        io_out_next = io_out_reg;
        done_next   = 1'b0;

        if (clear) begin
            active_next = 1'b0;
            phase_next  = P0;
            div_next    = '0;
            sck_next    = 1'b0;
            io_out_next = 4'h0;
        end else if (!active_reg) begin
            if (start) begin
                active_next = 1'b1;
                phase_next  = P0;
                div_next    = '0;
                sck_next    = 1'b0;
                io_out_next = tx_byte[7:4];
                lo_nib_next = tx_byte[3:0];
            end
        end else if (div_reg == DIV_LAST) begin
            div_next = '0;
            // Sampling happens on the edge that ends each SCK-high phase.
            case (phase_reg)
                P0: begin
                    phase_next = P1;
                    sck_next   = 1'b1;
                end
                P1: begin
                    phase_next   = P2;
                    sck_next     = 1'b0;
                    io_out_next  = lo_nib_reg;
                    rx_next[7:4] = io_in;
                end
                P2: begin
                    phase_next = P3;
                    sck_next   = 1'b1;
                end
                default: begin
                    phase_next   = P0;
                    sck_next     = 1'b0;
                    active_next  = 1'b0;
                    rx_next[3:0] = io_in;
                    done_next    = 1'b1;
                end
            endcase
        end else begin
            div_next = div_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            active_reg <= 1'b0;
            phase_reg  <= P0;
            div_reg    <= '0;
            lo_nib_reg <= 4'h0;
            rx_reg     <= 8'h00;
            sck_reg    <= 1'b0;
            io_out_reg <= 4'h0;
            done_reg   <= 1'b0;
        end else begin
            active_reg <= active_next;
            phase_reg  <= phase_next;
            div_reg    <= div_next;
            lo_nib_reg <= lo_nib_next;
            rx_reg     <= rx_next;
            sck_reg    <= sck_next;
            io_out_reg <= io_out_next;
            done_reg   <= done_next;
        end
    end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Round-robin arbiter sharing one quad-SPI target between the UART bridge and
// the management core, with CSB framing, per-transaction byte limit and stall timeout.
module qspi_bus_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int CLK_DIV      = 16,
    parameter int MAX_BYTES    = 8,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    qspi_bus_arbiter_if.slave    bus
);

    localparam int                 DIV_W      = $clog2(CLK_DIV + 1);
    localparam int                 STALL_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [DIV_W-1:0]   GUARD_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(IDLE_TIMEOUT - 1);
    localparam logic [7:0]         MAX_CNT    = 8'(MAX_BYTES);

    arb_state_t         state_reg, state_next;
    logic [1:0]         grant_reg, grant_next;
    logic               last_grant_reg, last_grant_next;
    logic [1:0]         tx_ready_reg, tx_ready_next;
    logic [7:0]         rx_data_reg, rx_data_next;
    logic [1:0]         rx_valid_reg, rx_valid_next;
    logic               busy_reg, busy_next;
    logic               csb_reg, csb_next;
    logic [3:0]         oe_reg, oe_next;
    logic [7:0]         byte_cnt_reg, byte_cnt_next;
    logic [STALL_W-1:0] stall_reg, stall_next;
    logic [DIV_W-1:0]   guard_reg, guard_next;
    logic               last_flag_reg, last_flag_next;

    logic [7:0] tx_byte_arr [NUM_REQ];
    logic       g_idx;
    logic       pick_idx;
    logic       go_release;
    logic       phy_start;
    logic       phy_clear;
    logic       phy_done;
    logic [7:0] phy_rx;
    logic [7:0] cnt_inc;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_tx_lane
        assign tx_byte_arr[gi] = bus.tx_data[8*gi +: 8];
    end

    assign g_idx    = grant_reg[REQ_MGMT];
    assign pick_idx = bus.req[~last_grant_reg] ? ~last_grant_reg : last_grant_reg;
    assign cnt_inc  = byte_cnt_reg + 8'd1;

    assign bus.grant      = grant_reg;
    assign bus.tx_ready   = tx_ready_reg;
    assign bus.rx_data    = rx_data_reg;
    assign bus.rx_valid   = rx_valid_reg;
    assign bus.busy       = busy_reg;
    assign bus.qspi_csb   = csb_reg;
    assign bus.qspi_io_oe = oe_reg;

    qspi_nibble_phy #(
        .CLK_DIV (CLK_DIV)
    ) u_phy (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (phy_clear),
        .start   (phy_start),
        .tx_byte (tx_byte_arr[g_idx]),
        .io_in   (bus.qspi_io_in),
        .sck     (bus.qspi_sck),
        .io_out  (bus.qspi_io_out),
        .done    (phy_done),
        .rx_byte (phy_rx)
    );

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        tx_ready_next   = tx_ready_reg;
        rx_data_next    = rx_data_reg;
        rx_valid_next   = 2'b00;
        csb_next        = csb_reg;
        oe_next         = oe_reg;
        byte_cnt_next   = byte_cnt_reg;
        stall_next      = stall_reg;
        guard_next      = guard_reg;
        last_flag_next  = last_flag_reg;
        phy_start       = 1'b0;
        phy_clear       = 1'b0;
        go_release      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    state_next      = WAIT_BYTE;
                    grant_next      = req_onehot(pick_idx);
                    tx_ready_next   = req_onehot(pick_idx);
                    last_grant_next = pick_idx;
                    csb_next        = 1'b0;
                    oe_next         = 4'hF;
                    stall_next      = '0;
                end
            end
            WAIT_BYTE: begin
                // A dropped request wins over a same-cycle handshake.
                if (!bus.req[g_idx]) begin
                    go_release = 1'b1;
                end else if (bus.tx_valid[g_idx]) begin
                    state_next     = SHIFT;
                    tx_ready_next  = 2'b00;
                    last_flag_next = bus.tx_last[g_idx];
                    stall_next     = '0;
                    phy_start      = 1'b1;
                end else if (stall_reg == STALL_LAST) begin
                    go_release = 1'b1;
                end else begin
                    stall_next = stall_reg + 1'b1;
                end
            end
            SHIFT: begin
                if (phy_done) begin
                    rx_data_next  = phy_rx;
                    rx_valid_next = grant_reg;
                    byte_cnt_next = cnt_inc;
                    if (last_flag_reg || cnt_inc == MAX_CNT) begin
                        go_release = 1'b1;
                    end else begin
                        state_next    = WAIT_BYTE;
                        tx_ready_next = grant_reg;
                        stall_next    = '0;
                    end
                end
            end
            RELEASE: begin
                state_next = GUARD;
                guard_next = '0;
            end
            GUARD: begin
                if (guard_reg == GUARD_LAST) begin
                    state_next = IDLE;
                    guard_next = '0;
                end else begin
                    guard_next = guard_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (go_release) begin
            state_next    = RELEASE;
            csb_next      = 1'b1;
            oe_next       = 4'h0;
            grant_next    = 2'b00;
            tx_ready_next = 2'b00;
            byte_cnt_next = 8'd0;
            stall_next    = '0;
            phy_clear     = 1'b1;
        end

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            grant_reg      <= 2'b00;
            last_grant_reg <= REQ_MGMT;
            tx_ready_reg   <= 2'b00;
            rx_data_reg    <= 8'h00;
            rx_valid_reg   <= 2'b00;
            busy_reg       <= 1'b0;
            csb_reg        <= 1'b1;
            oe_reg         <= 4'h0;
            byte_cnt_reg   <= 8'd0;
            stall_reg      <= '0;
            guard_reg      <= '0;
            last_flag_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            tx_ready_reg   <= tx_ready_next;
            rx_data_reg    <= rx_data_next;
            rx_valid_reg   <= rx_valid_next;
            busy_reg       <= busy_next;
            csb_reg        <= csb_next;
            oe_reg         <= oe_next;
            byte_cnt_reg   <= byte_cnt_next;
            stall_reg      <= stall_next;
            guard_reg      <= guard_next;
            last_flag_reg  <= last_flag_next;
        end
    end

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Scoreboard bench for qspi_bus_arbiter: directed transactions, a small QSPI
// target model, and a monitor that checks every rx_valid pulse against the queue.
module tb_qspi_bus_arbiter;

    localparam int D    = 2;
    localparam int MAXB = 8;
    localparam int TOUT = 64;

    typedef struct {
        logic [1:0] onehot;
        logic [7:0] rx;
        logic [7:0] mosi;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  drv_req = 2'b00;
    logic [15:0] drv_tx_data = 16'h0000;
    logic [1:0]  drv_tx_valid = 2'b00;
    logic [1:0]  drv_tx_last = 2'b00;
    logic [3:0]  drv_io_in = 4'h0;

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    logic       sck_prev = 1'b0;
    logic       nib_hi = 1'b1;
    logic [7:0] cur_resp = 8'h00;
    logic [7:0] mosi = 8'h00;

    always #5 clk = ~clk;

    qspi_bus_arbiter_if bus();

    assign bus.req        = drv_req;
    assign bus.tx_data    = drv_tx_data;
    assign bus.tx_valid   = drv_tx_valid;
    assign bus.tx_last    = drv_tx_last;
    assign bus.qspi_io_in = drv_io_in;

    qspi_bus_arbiter #(
        .CLK_DIV      (D),
        .MAX_BYTES    (MAXB),
        .IDLE_TIMEOUT (TOUT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
        checks++;
        if (act !== req_val) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req_val, cyc);
        end else begin
            $display("ok   %s = %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    function automatic logic [1:0] oh(input int idx);
        return (idx == 1) ? 2'b10 : 2'b01;
    endfunction

    // Target: answers cur_resp nibble by nibble on each SCK rise, records MOSI.
    always @(negedge clk) begin
        sck_prev <= bus.qspi_sck;
        if (bus.qspi_csb) begin
            nib_hi <= 1'b1;
        end else if (bus.qspi_sck && !sck_prev) begin
            if (nib_hi) begin
                drv_io_in <= cur_resp[7:4];
                mosi[7:4] <= bus.qspi_io_out;
            end else begin
                drv_io_in <= cur_resp[3:0];
                mosi[3:0] <= bus.qspi_io_out;
            end
            nib_hi <= ~nib_hi;
        end
    end

    // Monitor: every rx_valid pulse must match the head of the queue.
    always @(negedge clk) begin
        if (bus.rx_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rx_valid", 32'(bus.rx_valid), 32'd0);
            end else begin
                check("rx_valid", 32'(bus.rx_valid), 32'(exp_q[0].onehot));
                check("rx_data", 32'(bus.rx_data), 32'(exp_q[0].rx));
                check("mosi_byte", 32'(mosi), 32'(exp_q[0].mosi));
                check("rx_latency_cycle", 32'(cyc), 32'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        drv_req = 2'b00;
        drv_tx_valid = 2'b00;
        drv_tx_last = 2'b00;
        drv_tx_data = 16'h0000;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_byte(input int idx, input logic [7:0] data, input logic last,
                             input logic [7:0] resp);
        int n = 0;
        drv_tx_data[8*idx +: 8] = data;
        drv_tx_valid[idx] = 1'b1;
        drv_tx_last[idx] = last;
        while (bus.tx_ready[idx] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_seen", 32'(bus.tx_ready[idx]), 32'd1);
        if (bus.tx_ready[idx] === 1'b1) begin
            check("grant_at_accept", 32'(bus.grant), 32'(oh(idx)));
            check("csb_low_at_accept", 32'(bus.qspi_csb), 32'd0);
            cur_resp = resp;
            exp_q.push_back('{oh(idx), resp, data, cyc + 4*D + 2});
        end
        @(negedge clk);
        drv_tx_valid[idx] = 1'b0;
        drv_tx_last[idx] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int n;
        int hits;

        // Reset state, sampled while resetn is still low.
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_csb", 32'(bus.qspi_csb), 32'd1);
        check("rst_sck", 32'(bus.qspi_sck), 32'd0);
        check("rst_io_out", 32'(bus.qspi_io_out), 32'd0);
        check("rst_io_oe", 32'(bus.qspi_io_oe), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Single byte A5 from the UART bridge, target answers 3C.
        drv_req = 2'b01;
        send_byte(0, 8'hA5, 1'b1, 8'h3C);
        check("p0_io_out_hi", 32'(bus.qspi_io_out), 32'hA);
        check("p0_sck_low", 32'(bus.qspi_sck), 32'd0);
        check("shift_io_oe", 32'(bus.qspi_io_oe), 32'hF);
        check("shift_busy", 32'(bus.busy), 32'd1);
        repeat (2*D) @(negedge clk);
        check("p2_io_out_lo", 32'(bus.qspi_io_out), 32'h5);
        repeat (2*D + 1) @(negedge clk);
        check("csb_high_at_release", 32'(bus.qspi_csb), 32'd1);
        drv_req = 2'b00;
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            check("csb_high_guard", 32'(bus.qspi_csb), 32'd1);
        end

        // Both request together after reset: 0, then 1, then 0 again.
        do_reset();
        drv_req = 2'b11;
        send_byte(0, 8'h11, 1'b1, 8'h22);
        send_byte(1, 8'h33, 1'b1, 8'h44);
        send_byte(0, 8'h55, 1'b1, 8'h66);
        repeat (4*D + 1) @(negedge clk);
        drv_req = 2'b00;
        repeat (4) @(negedge clk);

        // Management core streams 10 bytes without last; frame splits after 8.
        do_reset();
        drv_req = 2'b10;
        for (int k = 0; k < 10; k++) begin
            send_byte(1, 8'(8'h40 + k), 1'b0, 8'(8'hC0 ^ k));
            if (k == MAXB - 1) begin
                repeat (4*D + 1) @(negedge clk);
                check("csb_high_after_max", 32'(bus.qspi_csb), 32'd1);
                check("grant_cleared_after_max", 32'(bus.grant), 32'd0);
                check("tx_ready_low_after_max", 32'(bus.tx_ready), 32'd0);
            end
        end
        repeat (4*D + 1) @(negedge clk);
        drv_req = 2'b00;
        @(negedge clk);
        check("csb_high_after_req_drop", 32'(bus.qspi_csb), 32'd1);
        repeat (2*D) @(negedge clk);

        // Stall timeout: tx_valid held low.
        do_reset();
        drv_req = 2'b01;
        n = 0;
        while (bus.tx_ready[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_tx_ready_seen", 32'(bus.tx_ready[0]), 32'd1);
        t0 = cyc;
        n = 0;
        while (bus.qspi_csb !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 32'(cyc - t0), 32'(TOUT));
        check("timeout_grant", 32'(bus.grant), 32'd0);
        check("timeout_tx_ready", 32'(bus.tx_ready), 32'd0);
        drv_req = 2'b00;
        repeat (2*D + 2) @(negedge clk);

        // Reset pulsed during P2 of a byte.
        do_reset();
        drv_req = 2'b01;
        send_byte(0, 8'h96, 1'b1, 8'h5A);
        repeat (2*D) @(negedge clk);
        check("p2_before_reset_io_out", 32'(bus.qspi_io_out), 32'h6);
        exp_q.delete();
        resetn = 1'b0;
        drv_req = 2'b00;
        @(negedge clk);
        check("midreset_csb", 32'(bus.qspi_csb), 32'd1);
        check("midreset_io_oe", 32'(bus.qspi_io_oe), 32'd0);
        check("midreset_grant", 32'(bus.grant), 32'd0);
        check("midreset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("midreset_sck", 32'(bus.qspi_sck), 32'd0);
        resetn = 1'b1;
        repeat (4*D) @(negedge clk);
        drv_req = 2'b01;
        send_byte(0, 8'h7E, 1'b1, 8'hE7);
        repeat (4*D + 1) @(negedge clk);
        drv_req = 2'b00;
        repeat (2*D + 2) @(negedge clk);

        // req dropped in the same cycle as tx_valid: byte must not be taken.
        do_reset();
        drv_req = 2'b01;
        n = 0;
        while (bus.tx_ready[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drop_tx_ready_seen", 32'(bus.tx_ready[0]), 32'd1);
        drv_req = 2'b00;
        drv_tx_data[7:0] = 8'hF0;
        drv_tx_valid[0] = 1'b1;
        @(negedge clk);
        drv_tx_valid[0] = 1'b0;
        check("drop_csb_release", 32'(bus.qspi_csb), 32'd1);
        check("drop_grant", 32'(bus.grant), 32'd0);
        check("drop_tx_ready", 32'(bus.tx_ready), 32'd0);
        hits = 0;
        for (int i = 0; i < 4*D + 2; i++) begin
            @(negedge clk);
            if (bus.qspi_sck === 1'b1) hits++;
        end
        check("drop_no_sck_activity", 32'(hits), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
